mmio_io_ctrl: RTL and testbench

- Sequencing controller between the core's memory-mapped IO path and its peripherals: UART transmitter, UART receiver, cycle counter and instruction counter.
- Owns the TX holding register, an RX byte FIFO and both counters, and runs the ready/valid handshakes with the UART.
- Returns registered read data to the core with the same 1-cycle latency as the synchronous data memory.
- Sits beside DMEM in the MEM stage; the core routes addresses with addr_in[31:28] == 4'h8 here.

---
 rtl/mmio_io_ctrl_if.sv | 31 +++
 rtl/mmio_io_ctrl.sv | 126 ++++++++++++
 tb/tb_mmio_io_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_ctrl_if.sv
// Core-side MMIO bus plus UART ready/valid handshakes for the IO controller.
// The slave modport is the controller; master is the core/UART side.
interface mmio_io_ctrl_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic [AWIDTH-1:0] addr_in;
  logic [DWIDTH-1:0] data_in;
  logic              we_in;
  logic              re_in;
  logic              inst_retire_in;
  logic [DWIDTH-1:0] data_out;
  logic [7:0]        uart_tx_data_out;
  logic              uart_tx_valid_out;
  logic              uart_tx_ready_in;
  logic [7:0]        uart_rx_data_in;
  logic              uart_rx_valid_in;
  logic              uart_rx_ready_out;

  modport slave (
    input  addr_in, data_in, we_in, re_in, inst_retire_in,
           uart_tx_ready_in, uart_rx_data_in, uart_rx_valid_in,
    output data_out, uart_tx_data_out, uart_tx_valid_out, uart_rx_ready_out
  );

  modport master (
    output addr_in, data_in, we_in, re_in, inst_retire_in,
           uart_tx_ready_in, uart_rx_data_in, uart_rx_valid_in,
    input  data_out, uart_tx_data_out, uart_tx_valid_out, uart_rx_ready_out
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// MMIO IO controller: UART TX holding register, RX byte FIFO, cycle and
// instruction counters, with 1-cycle registered read data like DMEM.
module mmio_io_ctrl #(
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned RX_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  mmio_io_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RXDATA = 32'h8000_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTR  = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNTCLR = 32'h8000_0018;

  logic [DWIDTH-1:0] data_q, data_d;
  logic              tx_full_q, tx_full_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        mem_q [RX_DEPTH];
  logic [7:0]        mem_d [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DWIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [DWIDTH-1:0] inst_cnt_q, inst_cnt_d;

  logic [31:0] addr32;
  logic        fifo_full, fifo_empty;
  logic        push, pop, tx_accept, tx_done, cnt_clear;
  logic        unused_data_hi;

  assign unused_data_hi = ^bus.data_in[DWIDTH-1:8];

  // Address decode and handshake qualifiers
  always_comb begin
    addr32     = 32'(bus.addr_in);
    fifo_full  = (count_q == CNT_W'(RX_DEPTH));
    fifo_empty = (count_q == '0);
    push       = bus.uart_rx_valid_in && !fifo_full;
    pop        = bus.re_in && (addr32 == ADDR_RXDATA) && !fifo_empty;
    tx_done    = tx_full_q && bus.uart_tx_ready_in;
    tx_accept  = bus.we_in && (addr32 == ADDR_TXDATA) && !tx_full_q;
    cnt_clear  = bus.we_in && (addr32 == ADDR_CNTCLR);
  end

  // Next-state for read data, TX register, RX FIFO and counters
  always_comb begin
    data_d     = data_q;
    tx_full_d  = tx_full_q;
    tx_data_d  = tx_data_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cyc_cnt_d  = cyc_cnt_q + DWIDTH'(1);
    inst_cnt_d = inst_cnt_q + DWIDTH'(bus.inst_retire_in);

    if (bus.re_in) begin
      case (addr32)
        ADDR_STATUS: data_d = DWIDTH'({!fifo_empty, !tx_full_q});
        ADDR_RXDATA: data_d = fifo_empty ? '0 : DWIDTH'(mem_q[rd_ptr_q]);
        ADDR_CYCLE:  data_d = cyc_cnt_q;
        ADDR_INSTR:  data_d = inst_cnt_q;
        default:     data_d = '0;
      endcase
    end

    // accept is gated by !tx_full_q, so it never overlaps a completing handshake
    if (tx_done) tx_full_d = 1'b0;
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_data_d = bus.data_in[7:0];
    end

    if (push) begin
      mem_d[wr_ptr_q] = bus.uart_rx_data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (cnt_clear) begin
      cyc_cnt_d  = '0;
      inst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      tx_full_q  <= 1'b0;
      tx_data_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tx_full_q  <= tx_full_d;
      tx_data_q  <= tx_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign bus.data_out          = data_q;
  assign bus.uart_tx_data_out  = tx_data_q;
  assign bus.uart_tx_valid_out = tx_full_q;
  assign bus.uart_rx_ready_out = !fifo_full;
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: vector table for TX/RX traffic plus
// hand-written sequences for reset, counters, wrap and mid-handshake reset.
module tb_mmio_io_ctrl;
  localparam logic [31:0] A_STAT = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INST = 32'h8000_0014;
  localparam logic [31:0] A_CLR  = 32'h8000_0018;
  localparam logic [31:0] A_NONE = 32'h8000_0020;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic [31:0] exp_data;
    logic        exp_tx_valid;
    logic [7:0]  exp_tx_data;
    logic        exp_rx_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  mmio_io_ctrl_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mmio_io_ctrl #(.AWIDTH(32), .DWIDTH(32), .RX_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                              input logic txr, input logic [31:0] ed, input logic etv,
                              input logic [7:0] etd, input logic err);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.rx_valid = rxv; v.rx_data = rxd; v.tx_ready = txr;
    v.exp_data = ed; v.exp_tx_valid = etv; v.exp_tx_data = etd; v.exp_rx_ready = err;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.we_in            = 1'b0;
    bus.re_in            = 1'b0;
    bus.addr_in          = '0;
    bus.data_in          = '0;
    bus.inst_retire_in   = 1'b0;
    bus.uart_tx_ready_in = 1'b0;
    bus.uart_rx_data_in  = '0;
    bus.uart_rx_valid_in = 1'b0;
  endtask

  initial begin
    //       we  re  addr    wdata        rxv rxd    txr exp_data      etv etd    err
    // TX: ready low for three cycles, second store dropped, handshake drops a third
    vecs.push_back(mk(1, 0, A_TX,   32'h1A5, 0, 8'h00, 0, 32'h0, 1, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h0, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 0, A_TX,   32'h33,  0, 8'h00, 0, 32'h0, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 0, A_TX,   32'h77,  0, 8'h00, 1, 32'h0, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h1, 0, 8'hA5, 1));
    // RX: fill to depth, overflow byte refused, drain in order, empty read
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h11, 0, 32'h1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h22, 0, 32'h1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h33, 0, 32'h1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h44, 0, 32'h1, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h99, 0, 32'h1, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h3, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h11, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h22, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h33, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h44, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h0,  0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h1,  0, 8'hA5, 1));
    // Simultaneous push and pop
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   1, 8'h55, 0, 32'h1,  0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   1, 8'h66, 0, 32'h55, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h3,  0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_RX,   32'h0,   0, 8'h00, 0, 32'h66, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h1,  0, 8'hA5, 1));
    // we+re together, unmapped read, write to read-only status ignored
    vecs.push_back(mk(1, 1, A_TX,   32'hC3,  0, 8'h00, 0, 32'h0,  1, 8'hC3, 1));
    vecs.push_back(mk(0, 0, A_STAT, 32'h0,   0, 8'h00, 1, 32'h0,  0, 8'hC3, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h1,  0, 8'hC3, 1));
    vecs.push_back(mk(0, 1, A_NONE, 32'h0,   0, 8'h00, 0, 32'h0,  0, 8'hC3, 1));
    vecs.push_back(mk(1, 1, A_STAT, 32'hFF,  0, 8'h00, 0, 32'h1,  0, 8'hC3, 1));
    vecs.push_back(mk(0, 1, A_STAT, 32'h0,   0, 8'h00, 0, 32'h1,  0, 8'hC3, 1));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset data_out", bus.data_out, 32'h0);
    check("reset tx_valid", 32'(bus.uart_tx_valid_out), 32'h0);
    check("reset tx_data", 32'(bus.uart_tx_data_out), 32'h0);
    check("reset rx_ready", 32'(bus.uart_rx_ready_out), 32'h1);
    rst = 1'b0;

    // Ten cycles after reset, retire on cycles 1,3,5,7; status read on cycle 1
    for (int i = 1; i <= 10; i++) begin
      bus.inst_retire_in = ((i % 2) == 1) && (i <= 7);
      bus.re_in          = (i == 1);
      bus.addr_in        = A_STAT;
      tick();
      if (i == 1) check("reset status", bus.data_out, 32'h1);
    end
    bus.inst_retire_in = 1'b0;
    bus.re_in = 1'b1; bus.addr_in = A_CYC;  tick();
    check("cycle count", bus.data_out, 32'd10);
    bus.addr_in = A_INST; tick();
    check("inst count", bus.data_out, 32'd4);
    bus.re_in = 1'b0; bus.we_in = 1'b1; bus.addr_in = A_CLR; bus.data_in = 32'hDEAD_BEEF;
    bus.inst_retire_in = 1'b1;
    tick();
    bus.we_in = 1'b0; bus.inst_retire_in = 1'b0;
    bus.re_in = 1'b1; bus.addr_in = A_CYC;  tick();
    check("cycle after clear", bus.data_out, 32'd0);
    bus.addr_in = A_INST; tick();
    check("inst after clear", bus.data_out, 32'd0);
    idle_inputs();

    foreach (vecs[i]) begin
      bus.we_in            = vecs[i].we;
      bus.re_in            = vecs[i].re;
      bus.addr_in          = vecs[i].addr;
      bus.data_in          = vecs[i].wdata;
      bus.uart_rx_valid_in = vecs[i].rx_valid;
      bus.uart_rx_data_in  = vecs[i].rx_data;
      bus.uart_tx_ready_in = vecs[i].tx_ready;
      tick();
      check($sformatf("v%0d data_out", i), bus.data_out, vecs[i].exp_data);
      check($sformatf("v%0d tx_valid", i), 32'(bus.uart_tx_valid_out), 32'(vecs[i].exp_tx_valid));
      check($sformatf("v%0d tx_data", i), 32'(bus.uart_tx_data_out), 32'(vecs[i].exp_tx_data));
      check($sformatf("v%0d rx_ready", i), 32'(bus.uart_rx_ready_out), 32'(vecs[i].exp_rx_ready));
    end
    idle_inputs();

    // Cycle counter wrap: preload all-ones, then two back-to-back reads
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    bus.re_in = 1'b1; bus.addr_in = A_CYC;
    tick();
    check("wrap pre", bus.data_out, 32'hFFFF_FFFF);
    tick();
    check("wrap post", bus.data_out, 32'h0);
    idle_inputs();

    // Reset while a TX byte is pending and an RX byte is buffered
    bus.we_in = 1'b1; bus.addr_in = A_TX; bus.data_in = 32'h5A;
    bus.uart_rx_valid_in = 1'b1; bus.uart_rx_data_in = 8'hAB;
    tick();
    idle_inputs();
    check("pending tx_valid", 32'(bus.uart_tx_valid_out), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midreset tx_valid", 32'(bus.uart_tx_valid_out), 32'h0);
    check("midreset tx_data", 32'(bus.uart_tx_data_out), 32'h0);
    check("midreset rx_ready", 32'(bus.uart_rx_ready_out), 32'h1);
    bus.re_in = 1'b1; bus.addr_in = A_STAT; tick();
    check("midreset status", bus.data_out, 32'h1);
    bus.addr_in = A_RX; tick();
    check("midreset rx empty", bus.data_out, 32'h0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
